// File: rtl/fifo_sync_af.sv
// Synchronous FIFO with programmable almost-full/almost-empty flags and a registered read port.
// Define FIFO_PEAK_EN to add the occupancy high-water-mark output 'peak'.
module fifo_sync_af #(
  parameter int unsigned DATA_SIZE  = 12,
  parameter int unsigned ADDR_SIZE  = 3,
  parameter int unsigned AF_DEFAULT = 6,
  parameter int unsigned AE_DEFAULT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic [ADDR_SIZE:0]   umbral_af,
  input  logic [ADDR_SIZE:0]   umbral_ae,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 fifo_af,
  output logic                 fifo_ae,
  output logic                 fifo_error,
`ifdef FIFO_PEAK_EN
  output logic [ADDR_SIZE:0]   peak,
`endif
  output logic [ADDR_SIZE:0]   count
);

  localparam int unsigned        DEPTH    = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_W  = (ADDR_SIZE + 1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] AF_DEF_W = (ADDR_SIZE + 1)'(AF_DEFAULT);
  localparam logic [ADDR_SIZE:0] AE_DEF_W = (ADDR_SIZE + 1)'(AE_DEFAULT);

  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [ADDR_SIZE-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_SIZE:0]   r_count, r_af_th, r_ae_th;
  logic [DATA_SIZE-1:0] r_data_out;
  logic                 r_valid, r_error;

  logic                 w_push_ok, w_pop_ok, w_err_evt;
  logic [ADDR_SIZE:0]   w_count_nxt, w_af_th_ld, w_ae_th_ld;

  assign fifo_empty = (r_count == '0);
  assign fifo_full  = (r_count == DEPTH_W);
  assign fifo_af    = (r_count >= r_af_th);
  assign fifo_ae    = (r_count <= r_ae_th);
  assign fifo_error = r_error;
  assign count      = r_count;
  assign data_out   = r_data_out;
  assign valid      = r_valid;

  // A pop frees the slot a same-cycle push writes, so a full FIFO accepts both.
  assign w_pop_ok  = pop & ~fifo_empty;
  assign w_push_ok = push & (~fifo_full | w_pop_ok);
  assign w_err_evt = (pop & fifo_empty) | (push & fifo_full & ~w_pop_ok);

  assign w_af_th_ld = (umbral_af == '0)     ? AF_DEF_W :
                      (umbral_af > DEPTH_W) ? DEPTH_W  : umbral_af;
  assign w_ae_th_ld = (umbral_ae == '0)     ? AE_DEF_W : umbral_ae;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
      r_af_th    <= w_af_th_ld;
      r_ae_th    <= w_ae_th_ld;
    end else begin
      r_count <= w_count_nxt;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= r_mem[r_rd_ptr];
        r_valid    <= 1'b1;
      end else begin
        r_data_out <= '0;
        r_valid    <= 1'b0;
      end
      if (w_err_evt) begin
        r_error <= 1'b1;
      end
    end
  end

`ifdef FIFO_PEAK_EN
  logic [ADDR_SIZE:0] r_peak;

  assign peak = r_peak;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_peak <= '0;
    end else if (w_count_nxt > r_peak) begin
      r_peak <= w_count_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_af.sv
// Randomized scoreboard bench for fifo_sync_af against a queue-based reference model.
module tb_fifo_sync_af;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [11:0] data_in = '0;
  logic [3:0]  umbral_af = '0;
  logic [3:0]  umbral_ae = '0;
  logic [11:0] data_out;
  logic        valid, fifo_empty, fifo_full, fifo_af, fifo_ae, fifo_error;
  logic [3:0]  count;
`ifdef FIFO_PEAK_EN
  logic [3:0]  peak;
`endif

  fifo_sync_af dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .data_in    (data_in),
    .umbral_af  (umbral_af),
    .umbral_ae  (umbral_ae),
    .data_out   (data_out),
    .valid      (valid),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_af    (fifo_af),
    .fifo_ae    (fifo_ae),
    .fifo_error (fifo_error),
`ifdef FIFO_PEAK_EN
    .peak       (peak),
`endif
    .count      (count)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [11:0] mq[$];     // reference FIFO contents
  logic [11:0] exp_q[$];  // scoreboard: words expected on data_out
  bit          m_err;
  int          m_af, m_ae, m_peak;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every presented word must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          chk("data_out", int'(data_out), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic check_state(input bit exp_valid);
    chk("count", int'(count), mq.size());
    chk("empty", int'(fifo_empty), int'(mq.size() == 0));
    chk("full", int'(fifo_full), int'(mq.size() == 8));
    chk("af", int'(fifo_af), int'(mq.size() >= m_af));
    chk("ae", int'(fifo_ae), int'(mq.size() <= m_ae));
    chk("error", int'(fifo_error), int'(m_err));
    chk("valid", int'(valid), int'(exp_valid));
    if (!exp_valid) chk("data_out_idle", int'(data_out), 0);
`ifdef FIFO_PEAK_EN
    chk("peak", int'(peak), m_peak);
`endif
  endtask

  task automatic do_reset(input logic [3:0] uaf, input logic [3:0] uae);
    reset = 1'b1;
    umbral_af = uaf;
    umbral_ae = uae;
    @(posedge clk);
    #1;
    reset = 1'b0;
    umbral_af = 4'($urandom);  // ignored outside reset
    umbral_ae = 4'($urandom);
    mq.delete();
    m_err  = 1'b0;
    m_peak = 0;
    m_af   = (uaf == 0) ? 6 : ((uaf > 8) ? 8 : int'(uaf));
    m_ae   = (uae == 0) ? 1 : int'(uae);
    check_state(1'b0);
  endtask

  task automatic step(input bit p, input bit q, input logic [11:0] d);
    bit pop_ok, push_ok;
    push = p;
    pop = q;
    data_in = d;
    pop_ok  = q && (mq.size() > 0);
    push_ok = p && ((mq.size() < 8) || pop_ok);
    if ((q && mq.size() == 0) || (p && mq.size() == 8 && !pop_ok)) m_err = 1'b1;
    if (pop_ok) exp_q.push_back(mq.pop_front());
    if (push_ok) mq.push_back(d);
    if (mq.size() > m_peak) m_peak = mq.size();
    @(posedge clk);
    #1;
    push = 1'b0;
    pop = 1'b0;
    check_state(pop_ok);
  endtask

  initial begin
    // T1: default thresholds
    do_reset(4'd0, 4'd0);
    step(0, 0, 12'h0);

    // T2: three words in, three out
    step(1, 0, 12'h1A5);
    step(1, 0, 12'h2B6);
    step(1, 0, 12'h3C7);
    repeat (3) step(0, 1, 12'h0);
    step(0, 0, 12'h0);

    // T3: overflow with the ninth push
    for (int i = 1; i <= 9; i++) step(1, 0, 12'(i));
    repeat (8) step(0, 1, 12'h0);
    step(0, 0, 12'h0);

    // T4: full with simultaneous push+pop
    do_reset(4'd0, 4'd0);
    for (int i = 0; i < 8; i++) step(1, 0, 12'(12'h40 + i));
    step(1, 1, 12'h0FF);
    repeat (8) step(0, 1, 12'h0);
    step(0, 0, 12'h0);

    // T5: empty with simultaneous push+pop
    do_reset(4'd0, 4'd0);
    step(1, 1, 12'h123);
    step(0, 1, 12'h0);
    step(0, 0, 12'h0);

    // T6: pointer wrap, then reset with five words stored
    do_reset(4'd0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 12'(12'h500 + i));
      step(0, 1, 12'h0);
    end
    for (int i = 0; i < 5; i++) step(1, 0, 12'(12'h600 + i));
    step(0, 0, 12'h0);
    do_reset(4'd0, 4'd0);

    // Programmed and clamped thresholds
    do_reset(4'd12, 4'd3);
    for (int i = 0; i < 8; i++) step(1, 0, 12'(i));
    repeat (8) step(0, 1, 12'h0);
    do_reset(4'd4, 4'd5);
    for (int i = 0; i < 8; i++) step(1, 0, 12'(i));
    repeat (8) step(0, 1, 12'h0);

    // Random traffic with shifting push/pop bias and occasional reset
    for (int ph = 0; ph < 6; ph++) begin
      int pp, qp;
      pp = 30 + 10 * ph;
      qp = 80 - 10 * ph;
      for (int i = 0; i < 120; i++) begin
        if ($urandom_range(0, 99) < 2) begin
          step(0, 0, 12'h0);
          do_reset(4'($urandom), 4'($urandom));
        end else begin
          step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < qp, 12'($urandom));
        end
      end
    end

    repeat (2) step(0, 0, 12'h0);
    chk("pending_outputs", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
